// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one shift-add multiplier between two clients.
// Define MULT_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles with err.
module mult_arbiter #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic sign0,
    input  logic sign1,
    input  logic valid,
    output logic start,
    output logic sign,
    output logic gnt0,
    output logic gnt1,
    output logic done0,
    output logic done1,
    output logic busy,
    output logic err
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
    state_t state, state_n;
    logic ptr, ptr_n, gsel, gsel_n, sign_q, sign_n, valid_q, rise, tmo;
    assign rise = valid & ~valid_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 1'b1;
            gsel    <= 1'b0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gsel    <= gsel_n;
            sign_q  <= sign_n;
            valid_q <= valid;
        end
    end
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gsel_n  = gsel;
        sign_n  = sign_q;
        case (state)
            IDLE: if (req0 | req1) begin
                // on a tie the client that did not finish last wins
                gsel_n  = (req0 & req1) ? ~ptr : req1;
                sign_n  = gsel_n ? sign1 : sign0;
                state_n = LAUNCH;
            end
            LAUNCH: state_n = WAIT;
            WAIT: state_n = (rise | tmo) ? DONE : WAIT;
            DONE: begin
                ptr_n   = gsel;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
`ifdef MULT_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic err_q;
    assign tmo = (state == WAIT) && (cnt == CNT_W'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt <= (state == LAUNCH) ? '0 : (state == WAIT) ? cnt + CNT_W'(1) : cnt;
            // a valid edge coinciding with the timeout counts as a normal completion
            if (state == WAIT && state_n == DONE) err_q <= ~rise;
        end
    end
    assign err = (state == DONE) & err_q;
`else
    logic unused_par;
    assign unused_par = ^{TIMEOUT[0], CNT_W[0]};
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    assign busy  = state != IDLE;
    assign start = state == LAUNCH;
    assign sign  = sign_q;
    assign gnt0  = busy & ~gsel;
    assign gnt1  = busy & gsel;
    assign done0 = (state == DONE) & ~gsel;
    assign done1 = (state == DONE) & gsel;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized and directed stimulus against a transaction-level model of the arbiter.
module tb_mult_arbiter;
    localparam int TO = 40;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, req0, req1, sign0, sign1, valid;
    logic start, sign, gnt0, gnt1, done0, done1, busy, err;
    always #5 clk = ~clk;
    mult_arbiter #(.TIMEOUT(TO), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .sign0(sign0), .sign1(sign1),
        .valid(valid), .start(start), .sign(sign), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .busy(busy), .err(err)
    );
    logic [7:0] expq[$];
    logic [7:0] me, ma, mk;
    int nvec = 0, nfail = 0, ncyc = 0;
    // model: owner of the multiplier (-1 none), cycles since launch, completion flag
    int owner = -1, ptr = 1, t = 0;
    bit sgn = 0, fin = 0, errf = 0, vq = 0;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            ma = {start, sign, gnt0, gnt1, done0, done1, busy, err};
            mk = me[1] ? 8'hFF : 8'hBF;
            nvec++;
            if ((ma & mk) != (me & mk)) begin
                nfail++;
                $display("FAIL outputs cycle %0d {start,sign,gnt0,gnt1,done0,done1,busy,err}: got %b expected %b",
                         ncyc, ma, me);
            end
        end
    end
    task automatic cyc(input bit r0, input bit r1, input bit s0, input bit s1, input bit v, input bit rst);
        bit rise;
        req0 = r0; req1 = r1; sign0 = s0; sign1 = s1; valid = v; reset = rst;
        @(posedge clk);
        #1;
        ncyc++;
        if (rst) begin
            owner = -1; ptr = 1; vq = 0; fin = 0; errf = 0;
        end else begin
            rise = v & ~vq;
            if (owner < 0) begin
                if (r0 | r1) begin
                    owner = (r0 & r1) ? 1 - ptr : (r1 ? 1 : 0);
                    sgn = owner == 1 ? s1 : s0;
                    t = 0; fin = 0; errf = 0;
                end
            end else if (fin) begin
                ptr = owner; owner = -1; fin = 0;
            end else if (t == 0) begin
                t = 1;
            end else if (rise || (TMO && t == TO)) begin
                fin = 1; errf = !rise;
            end else begin
                t++;
            end
            vq = v;
        end
        expq.push_back({owner >= 0 && t == 0 && !fin, sgn, owner == 0, owner == 1,
                        fin && owner == 0, fin && owner == 1, owner >= 0, fin && errf});
    endtask
    task automatic idle(input int n, input bit v);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, v, 0);
    endtask
    initial begin
        bit v;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 0);
        idle(8, 0);
        idle(3, 1);
        idle(4, 0);
        for (int i = 0; i < 48; i++) cyc(1, 1, i[0], ~i[1], (i % 6) >= 3, 0);
        idle(6, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(3, 0);
        idle(8, 1);
        cyc(1, 0, 1, 0, 1, 0);
        idle(6, 1);
        idle(2, 0);
        idle(3, 1);
        idle(4, 0);
        cyc(0, 1, 0, 1, 0, 0);
        idle(4, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        idle(4, 0);
        idle(2, 1);
        idle(4, 0);
        cyc(0, 1, 0, 1, 0, 0);
        idle(5, 0);
        idle(2, 1);
        idle(4, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(100, 0);
        idle(2, 1);
        idle(4, 0);
        v = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) v = ~v;
            cyc($urandom_range(2) == 0, $urandom_range(2) == 0, 1'($urandom), 1'($urandom), v,
                $urandom_range(99) == 0);
        end
        idle(4, 0);
        @(negedge clk);
        #1;
        nvec++;
        if (expq.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
